// File: rtl/result_collect.sv
// Collects add/mul/sine results into per-unit pending registers and drains them, tagged, into a FWFT queue.
// Latency: done at edge k -> pending at k -> queued at k+1 (when it wins arbitration) -> visible at the read port.
// Backpressure: out_fifo_hold throttles the decoder early; a result that arrives while its pending register is still occupied is dropped and sets overflow.

module fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     push_vld,
   output logic                     push_rdy,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop_vld,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   // Acceptance is decided on the pre-edge count, so a pop cannot make room for a push at full.
   assign push_rdy = (cnt_q < FULL_CNT);
   assign do_push  = push_vld && push_rdy;
   assign do_pop   = pop_vld && (cnt_q != '0);
   assign head_dat = mem[rd_ptr];
   assign cnt      = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

module result_collect #(
   parameter int DEPTH       = 8,
   parameter int HOLD_MARGIN = 3
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     add_done,
   input  logic [31:0]              add_result,
   input  logic                     mul_done,
   input  logic [31:0]              mul_result,
   input  logic                     sine_done,
   input  logic [31:0]              sine_result,
   input  logic                     read_strobe,
   output logic                     data_valid,
   output logic [31:0]              read_data,
   output logic [2:0]               read_tag,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     out_fifo_hold,
   output logic                     overflow
);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int THR = DEPTH - HOLD_MARGIN;
   localparam logic [CW:0] HOLD_THR = THR[CW:0];

   logic [2:0]  done;
   logic [31:0] res [3];
   logic [2:0]  pend_vld;
   logic [31:0] pend_dat [3];
   logic [2:0]  grant;
   logic [2:0]  drain;
   logic [31:0] wr_res;
   logic        wr_vld;
   logic        wr_rdy;
   logic [34:0] head_dat;
   logic [CW:0] occ;

   assign done   = {sine_done, mul_done, add_done};
   assign res[0] = add_result;
   assign res[1] = mul_result;
   assign res[2] = sine_result;

   // Fixed priority add > mul > sine; the grant doubles as the one-hot tag.
   always_comb begin
      grant = 3'b000;
      if (pend_vld[0]) begin
         grant = 3'b001;
      end else if (pend_vld[1]) begin
         grant = 3'b010;
      end else if (pend_vld[2]) begin
         grant = 3'b100;
      end
   end

   always_comb begin
      wr_res = pend_dat[0];
      if (grant[1]) begin
         wr_res = pend_dat[1];
      end else if (grant[2]) begin
         wr_res = pend_dat[2];
      end
   end

   assign wr_vld = |pend_vld;
   assign drain  = (wr_vld && wr_rdy) ? grant : 3'b000;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pend_vld <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
               if (pend_vld[i] && !drain[i]) begin
                  overflow <= 1'b1;
               end else begin
                  pend_vld[i] <= 1'b1;
               end
            end else if (drain[i]) begin
               pend_vld[i] <= 1'b0;
            end
         end
      end
   end

   // Result storage needs no reset; the valid flags alone decide what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (done[i] && (!pend_vld[i] || drain[i])) begin
            pend_dat[i] <= res[i];
         end
      end
   end

   fifo #(
      .WIDTH (35),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .n_rst    (n_rst),
      .push_vld (wr_vld),
      .push_rdy (wr_rdy),
      .push_dat ({grant, wr_res}),
      .pop_vld  (read_strobe),
      .head_dat (head_dat),
      .cnt      (count)
   );

   assign data_valid = (count != '0);
   assign read_data  = data_valid ? head_dat[31:0]  : 32'd0;
   assign read_tag   = data_valid ? head_dat[34:32] : 3'b000;

   // Pending results are counted as occupancy so that everything already captured still has a slot.
   always_comb begin
      occ = {1'b0, count};
      for (int i = 0; i < 3; i++) begin
         occ = occ + {{CW{1'b0}}, pend_vld[i]};
      end
   end

   assign out_fifo_hold = (occ >= HOLD_THR);
endmodule

// File: tb/tb_result_collect.sv
// Bench for result_collect: table-driven vectors plus hand sequences, checked against a scoreboard queue.
module tb_result_collect;
   logic        clk = 1'b0;
   logic        n_rst;
   logic        add_done, mul_done, sine_done;
   logic [31:0] add_result, mul_result, sine_result;
   logic        read_strobe;
   logic        data_valid;
   logic [31:0] read_data;
   logic [2:0]  read_tag;
   logic [3:0]  count;
   logic        out_fifo_hold;
   logic        overflow;

   typedef struct {
      logic        a_d;
      logic [31:0] a_r;
      logic        m_d;
      logic [31:0] m_r;
      logic        s_d;
      logic [31:0] s_r;
      int          exp_cnt;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      logic [2:0]  tag;
   } ent_t;

   ent_t sb[$];
   vec_t vecs[5];
   int   n_cmp = 0;
   int   n_bad = 0;

   result_collect #(.DEPTH(8), .HOLD_MARGIN(3)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .add_done      (add_done),
      .add_result    (add_result),
      .mul_done      (mul_done),
      .mul_result    (mul_result),
      .sine_done     (sine_done),
      .sine_result   (sine_result),
      .read_strobe   (read_strobe),
      .data_valid    (data_valid),
      .read_data     (read_data),
      .read_tag      (read_tag),
      .count         (count),
      .out_fifo_hold (out_fifo_hold),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [2:0] t);
      ent_t e;
      e.dat = d;
      e.tag = t;
      sb.push_back(e);
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, ".data_valid"}, {31'd0, data_valid}, 32'd0);
      chk({nm, ".read_data"}, read_data, 32'd0);
      chk({nm, ".read_tag"}, {29'd0, read_tag}, 32'd0);
      chk({nm, ".count"}, {28'd0, count}, 32'd0);
      chk({nm, ".hold"}, {31'd0, out_fifo_hold}, 32'd0);
      chk({nm, ".overflow"}, {31'd0, overflow}, 32'd0);
   endtask

   // Compare the head against the scoreboard front, then pop it with one strobe cycle.
   task automatic pop_head(input string nm);
      ent_t e;
      e = sb.pop_front();
      chk({nm, ".valid"}, {31'd0, data_valid}, 32'd1);
      chk({nm, ".data"}, read_data, e.dat);
      chk({nm, ".tag"}, {29'd0, read_tag}, {29'd0, e.tag});
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
   endtask

   task automatic drain_all(input string nm);
      int guard = 0;
      while (sb.size() > 0 && guard < 64) begin
         if (data_valid) pop_head(nm);
         else step();
         guard++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s.drain_timeout: %0d entries never appeared, expected 0 left", nm, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      n_rst = 1'b0;
      add_done = 1'b0; mul_done = 1'b0; sine_done = 1'b0;
      add_result = '0; mul_result = '0; sine_result = '0;
      read_strobe = 1'b0;

      vecs[0] = '{1'b1, 32'h11, 1'b1, 32'h22, 1'b1, 32'h33, 3};
      vecs[1] = '{1'b0, 32'h0, 1'b1, 32'hAA, 1'b0, 32'h0, 1};
      vecs[2] = '{1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'h5, 2};
      vecs[3] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1};
      vecs[4] = '{1'b1, 32'h0, 1'b1, 32'h80000001, 1'b0, 32'h0, 2};

      #12;
      chk_idle("in_reset");
      step();
      n_rst = 1'b1;
      step();
      step();
      chk_idle("after_reset");

      // Single add: two edges to the read port.
      add_done = 1'b1; add_result = 32'h2;
      push_exp(32'h2, 3'b001);
      step();
      add_done = 1'b0;
      chk("lat.pending_only", {31'd0, data_valid}, 32'd0);
      step();
      chk("lat.count", {28'd0, count}, 32'd1);
      pop_head("lat");
      chk("lat.count_after_pop", {28'd0, count}, 32'd0);
      chk("lat.valid_after_pop", {31'd0, data_valid}, 32'd0);

      // Table vectors: drive one cycle, let pending drain, then read back in priority order.
      foreach (vecs[v]) begin
         add_done = vecs[v].a_d; add_result = vecs[v].a_r;
         mul_done = vecs[v].m_d; mul_result = vecs[v].m_r;
         sine_done = vecs[v].s_d; sine_result = vecs[v].s_r;
         if (vecs[v].a_d) push_exp(vecs[v].a_r, 3'b001);
         if (vecs[v].m_d) push_exp(vecs[v].m_r, 3'b010);
         if (vecs[v].s_d) push_exp(vecs[v].s_r, 3'b100);
         step();
         add_done = 1'b0; mul_done = 1'b0; sine_done = 1'b0;
         repeat (3) step();
         chk($sformatf("vec%0d.count", v), {28'd0, count}, vecs[v].exp_cnt);
         chk($sformatf("vec%0d.overflow", v), {31'd0, overflow}, 32'd0);
         drain_all($sformatf("vec%0d", v));
         chk($sformatf("vec%0d.empty", v), {28'd0, count}, 32'd0);
      end

      // Back-to-back adds: hold threshold, full FIFO, ninth result parked in pending.
      for (int i = 1; i <= 9; i++) begin
         add_done = 1'b1; add_result = 32'h200 + i;
         push_exp(32'h200 + i, 3'b001);
         step();
         chk($sformatf("fill%0d.hold", i), {31'd0, out_fifo_hold}, (i >= 5) ? 32'd1 : 32'd0);
      end
      add_done = 1'b0;
      chk("fill.count_full", {28'd0, count}, 32'd8);
      step();
      chk("fill.no_write_at_full", {28'd0, count}, 32'd8);
      chk("fill.overflow", {31'd0, overflow}, 32'd0);
      pop_head("fill.pop");
      chk("fill.count_after_pop", {28'd0, count}, 32'd7);
      step();
      chk("fill.ninth_entered", {28'd0, count}, 32'd8);

      add_done = 1'b1; add_result = 32'h300;
      push_exp(32'h300, 3'b001);
      step();
      add_result = 32'h301;
      step();
      add_done = 1'b0;
      chk("ovf.set", {31'd0, overflow}, 32'd1);
      step();
      chk("ovf.sticky", {31'd0, overflow}, 32'd1);
      chk("ovf.count", {28'd0, count}, 32'd8);
      pop_head("ovf.head0");
      pop_head("ovf.head1");
      chk("ovf.sticky2", {31'd0, overflow}, 32'd1);

      n_rst = 1'b0;
      #2;
      chk_idle("mid_reset");
      sb.delete();
      step();
      n_rst = 1'b1;
      step();
      step();
      chk_idle("post_mid_reset");

      // Pointer wrap with simultaneous write and pop.
      add_done = 1'b1; add_result = 32'h100; push_exp(32'h100, 3'b001);
      step();
      add_result = 32'h101; push_exp(32'h101, 3'b001);
      step();
      add_done = 1'b0;
      step();
      chk("wrap.prefill", {28'd0, count}, 32'd2);
      for (int i = 2; i <= 9; i++) begin
         ent_t e;
         e = sb.pop_front();
         chk($sformatf("wrap%0d.data", i), read_data, e.dat);
         chk($sformatf("wrap%0d.tag", i), {29'd0, read_tag}, 32'd1);
         add_done = 1'b1; add_result = 32'h100 + i;
         push_exp(32'h100 + i, 3'b001);
         read_strobe = 1'b1;
         step();
         add_done = 1'b0; read_strobe = 1'b0;
         chk($sformatf("wrap%0d.count", i), {28'd0, count}, 32'd1);
      end
      drain_all("wrap.tail");
      step();
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
      chk_idle("empty_read");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
